datamem_ctrl: RTL
=================

DATAMEM_CTRL -- requirements
Module: datamem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9: byte-address width; memory holds 2**(ADDR_W-2) 32-bit words.
REQ-002 Parameter SPLIT_MISALIGNED, default 1: 1 = split misaligned accesses into two word accesses; 0 = reject them with an error response.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  one-cycle pulse marking response completion.
REQ-012 rsp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  qualified by rsp_valid; illegal funct3 or rejected misaligned access.

Function
REQ-014 Handshake: request accepted on a rising edge where req_valid && req_ready; req_ready = (state == IDLE) && rst_n.
REQ-015 Responses have no backpressure; rsp_valid is high for exactly one cycle per accepted request.
REQ-016 Storage: synchronous word array with 4 byte-lane write enables; contents not reset.
REQ-017 Misaligned: H with addr[0]=1, or W with addr[1:0]!=0; B never misaligned.
REQ-018 Aligned/legal access: memory access on the accept edge; rsp_valid asserted the following cycle (latency 1).
REQ-019 Loads: byte/half extracted from lane addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-020 Stores: only lanes covered by the access written (SB 1 lane, SH 2, SW 4); other lanes unchanged.
REQ-021 Illegal funct3 (011, 110, 111; 100/101 with req_we=1): no memory write, rsp_err=1, rsp_rdata=0, latency 1.
REQ-022 FSM states: IDLE, SPLIT. IDLE->SPLIT on accepting a misaligned legal request when SPLIT_MISALIGNED=1; SPLIT->IDLE unconditionally after one cycle.
REQ-023 Split access: accept edge covers low word W0 = addr & ~3 (lanes addr[1:0]..3); SPLIT edge covers W1 = W0+4 (remaining lanes); rsp_valid the cycle after SPLIT (latency 2); req_ready low during SPLIT.
REQ-024 Split load: result assembled little-endian from W0 upper bytes and W1 lower bytes, then extended per REQ-019.
REQ-025 Word-index wrap-around: W1 beyond the last word wraps to word 0.
REQ-026 SPLIT_MISALIGNED=0: misaligned request performs no write; rsp_err=1, rsp_rdata=0, latency 1.
REQ-027 Back-to-back: a load accepted the cycle after a store to the same word returns the newly written data.
REQ-028 Address, funct3, wdata and we latched on accept; input changes during SPLIT have no effect.

Reset
REQ-029 While rst_n=0 on a rising edge: state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0; req_ready=1 the first cycle after release.
REQ-030 Reset during SPLIT abandons the access: W0 write stays committed, W1 not written, no response issued.

Verification
REQ-031 SW 0xA1B2C3D4 @0x10; LW @0x10 -> rsp_rdata=0xA1B2C3D4, rsp_err=0, rsp_valid 1 cycle after each accept.
REQ-032 After REQ-031: LB @0x13 -> 0xFFFFFFA1; LBU @0x13 -> 0x000000A1; LHU @0x12 -> 0x0000A1B2; LH @0x10 -> 0xFFFFC3D4.
REQ-033 SPLIT=1: SW 0x11223344 @0x0E -> req_ready low 1 cycle, rsp 2 cycles after accept; LW @0x0C -> 0x3344xxxx upper half, LW @0x10 low half 0x1122; LW @0x0E -> 0x11223344.
REQ-034 SPLIT=1, ADDR_W=9: SH 0xBEEF @0x1FF -> byte 0x1FF=0xEF, byte 0x000=0xBE; LHU @0x1FF -> 0x0000BEEF.
REQ-035 SPLIT=0: LW @0x02 -> rsp_err=1, rsp_rdata=0, latency 1; funct3=011 store -> rsp_err=1, memory unchanged.
REQ-036 Assert rst_n=0 on the SPLIT cycle of SW 0xCAFEF00D @0x21 -> no rsp_valid; word 0x20 lanes 1-3 updated, word 0x24 unchanged; req_ready=1 after release.

Source files
------------

// File: rtl/datamem_ctrl.sv
// Byte-addressable data memory controller for RV32I loads/stores.
// Misaligned accesses are either split over two word cycles or rejected.
module datamem_ctrl #(
    parameter int ADDR_W           = 9,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WI_W  = ADDR_W - 2;
    localparam int DEPTH = 1 << WI_W;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t state;

    logic [31:0] mem [DEPTH];

    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [2:0]        l_f3;
    logic [31:0]       l_wdata;
    logic [31:0]       l_w0;

    logic              accept;
    logic              in_split;
    logic              legal;
    logic              misal;
    logic              do_acc;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [2:0]        op_f3;
    logic [31:0]       op_wdata;
    logic [3:0]        bm;
    logic [7:0]        m8;
    logic [63:0]       d64;
    logic [WI_W-1:0]   mem_idx;
    logic [3:0]        wr_en;
    logic [31:0]       wr_data;
    logic [31:0]       rd_word;
    logic [63:0]       win;
    logic [63:0]       shifted;
    logic [31:0]       ld_val;

    function automatic logic [31:0] ext(input logic [31:0] v, input logic [2:0] f);
        case (f)
            3'b000:  ext = {{24{v[7]}}, v[7:0]};
            3'b001:  ext = {{16{v[15]}}, v[15:0]};
            3'b100:  ext = {24'b0, v[7:0]};
            3'b101:  ext = {16'b0, v[15:0]};
            default: ext = v;
        endcase
    endfunction

    assign req_ready = (state == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign in_split  = (state == SPLIT);

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_we;
            default:                legal = 1'b0;
        endcase
    end

    assign misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign do_acc = accept && legal && (!misal || SPLIT_MISALIGNED);

    assign op_we    = in_split ? l_we    : req_we;
    assign op_addr  = in_split ? l_addr  : req_addr;
    assign op_f3    = in_split ? l_f3    : req_funct3;
    assign op_wdata = in_split ? l_wdata : req_wdata;

    always_comb begin
        case (op_f3[1:0])
            2'b00:   bm = 4'b0001;
            2'b01:   bm = 4'b0011;
            default: bm = 4'b1111;
        endcase
    end

    // 8-byte window over W0/W1: low nibble hits W0, high nibble spills into W1
    assign m8  = {4'b0, bm} << op_addr[1:0];
    assign d64 = {32'b0, op_wdata} << {op_addr[1:0], 3'b000};

    assign mem_idx = in_split ? l_addr[ADDR_W-1:2] + WI_W'(1)
                              : req_addr[ADDR_W-1:2];

    always_comb begin
        wr_en   = 4'b0000;
        wr_data = d64[31:0];
        if (in_split) begin
            wr_data = d64[63:32];
            if (op_we && rst_n)
                wr_en = m8[7:4];
        end else if (do_acc && req_we) begin
            wr_en = m8[3:0];
        end
    end

    assign rd_word = mem[mem_idx];
    assign win     = in_split ? {rd_word, l_w0} : {32'b0, rd_word};
    assign shifted = win >> {op_addr[1:0], 3'b000};
    assign ld_val  = ext(shifted[31:0], op_f3);

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (wr_en[b])
                mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_we    <= req_we;
                        l_addr  <= req_addr;
                        l_f3    <= req_funct3;
                        l_wdata <= req_wdata;
                        l_w0    <= rd_word;
                        if (!legal || (misal && !SPLIT_MISALIGNED)) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'b0;
                        end else if (misal) begin
                            state <= SPLIT;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= req_we ? 32'b0 : ld_val;
                        end
                    end
                end
                SPLIT: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= op_we ? 32'b0 : ld_val;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
